// File: rtl/maxpool_ctrl_pkg.sv
// Shared constants, defaults and state encoding for the streaming max-pool sequencer.
package maxpool_ctrl_pkg;

  // Pool input geometry follows the convolution stage that feeds it.
  localparam int FM_SIZE     = 10;
  localparam int KERNEL_SIZE = 3;
  localparam int PADDING     = 0;
  localparam int STRIDE      = 1;

  localparam int DEF_IN_SIZE   = (FM_SIZE + 2 * PADDING - KERNEL_SIZE) / STRIDE + 1;
  localparam int DEF_POOL_SIZE = 2;
  localparam int DEF_DATA_W    = 48;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pool_state_e;

  // Width able to hold the values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/maxpool_ctrl_row_buf.sv
// Row buffer of partial window maxima: one write port, one combinational read port.
module pool_row_buf #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 48
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int IDX_W = maxpool_ctrl_pkg::cnt_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: this array is small and register-based, so clearing it on reset is cheap and
  // keeps read data defined; a RAM-mapped buffer would leave its contents unreset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (i_we && (i_waddr < ADDR_W'(DEPTH))) begin
      mem[i_waddr[IDX_W-1:0]] <= i_wdata;
    end
  end

  // Addresses past the pooled columns belong to discarded samples and read as zero.
  assign o_rdata = (i_raddr < ADDR_W'(DEPTH)) ? mem[i_raddr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/maxpool_ctrl.sv
// Streaming 2-D max-pool sequencer: raster samples in, one max per POOLxPOOL window out.
module maxpool_ctrl
  import maxpool_ctrl_pkg::*;
#(
  parameter int IN_SIZE   = DEF_IN_SIZE,
  parameter int POOL_SIZE = DEF_POOL_SIZE,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy,
  output logic              o_done
);

  localparam int OUT_SIZE = IN_SIZE / POOL_SIZE;
  localparam int KEEP_LIM = OUT_SIZE * POOL_SIZE;
  localparam int CNT_W    = cnt_w(IN_SIZE + 1);
  localparam int WIN_W    = cnt_w(POOL_SIZE);
  localparam int OC_W     = cnt_w(OUT_SIZE + 1);

  typedef logic signed [DATA_W-1:0] sample_t;

  function automatic sample_t smax(input sample_t a, input sample_t b);
    return (a > b) ? a : b;
  endfunction

  pool_state_e state_q, state_d;

  logic [CNT_W-1:0] row_q, col_q;
  logic [WIN_W-1:0] cr_q, cc_q;
  logic [OC_W-1:0]  oc_q;
  sample_t          acc_q;

  sample_t din, buf_rd, h_val, comb_val;
  logic    accept, keep, row_last, col_last, cc_last, cr_last, buf_we;
  logic [DATA_W-1:0] buf_rdata;

  assign din      = i_data;
  assign buf_rd   = buf_rdata;
  assign accept   = (state_q == RUN) && i_valid && !i_start;
  assign row_last = (row_q == CNT_W'(IN_SIZE - 1));
  assign col_last = (col_q == CNT_W'(IN_SIZE - 1));
  assign cc_last  = (cc_q == WIN_W'(POOL_SIZE - 1));
  assign cr_last  = (cr_q == WIN_W'(POOL_SIZE - 1));
  assign keep     = (row_q < CNT_W'(KEEP_LIM)) && (col_q < CNT_W'(KEEP_LIM));

  // With a 1-wide window every sample is its own horizontal max.
  assign h_val    = (POOL_SIZE == 1) ? din : smax(acc_q, din);
  assign comb_val = (cr_q == '0) ? h_val : smax(buf_rd, h_val);
  assign buf_we   = accept && keep && cc_last;

  pool_row_buf #(
    .DEPTH  (OUT_SIZE),
    .ADDR_W (OC_W),
    .DATA_W (DATA_W)
  ) u_row_buf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (buf_we),
    .i_waddr (oc_q),
    .i_wdata (comb_val),
    .i_raddr (oc_q),
    .o_rdata (buf_rdata)
  );

  // NOTE: every output of this block gets a default before the case, so no path can
  // leave state_d unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_start) state_d = RUN;
      RUN: begin
        if (i_start)                           state_d = RUN;
        else if (accept && row_last && col_last) state_d = DONE;
      end
      DONE:    state_d = i_start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      cr_q    <= '0;
      cc_q    <= '0;
      oc_q    <= '0;
      acc_q   <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      state_q <= state_d;
      o_valid <= 1'b0;
      if (i_start) begin
        row_q <= '0;
        col_q <= '0;
        cr_q  <= '0;
        cc_q  <= '0;
        oc_q  <= '0;
        acc_q <= '0;
      end else if (accept) begin
        if (col_last) begin
          col_q <= '0;
          cc_q  <= '0;
          oc_q  <= '0;
          row_q <= row_q + CNT_W'(1);
          cr_q  <= cr_last ? '0 : cr_q + WIN_W'(1);
        end else begin
          col_q <= col_q + CNT_W'(1);
          cc_q  <= cc_last ? '0 : cc_q + WIN_W'(1);
          if (cc_last) oc_q <= oc_q + OC_W'(1);
        end
        if (keep) begin
          acc_q <= (cc_q == '0) ? din : smax(acc_q, din);
          if (cc_last && cr_last) begin
            o_valid <= 1'b1;
            o_data  <= comb_val;
          end
        end
      end
    end
  end

  assign o_busy = (state_q == RUN);
  assign o_done = (state_q == DONE);

endmodule

// File: tb/tb_maxpool_ctrl.sv
// Self-checking bench: directed and random frames on a 4x4 and a 5x5 pool instance.
module tb_maxpool_ctrl;

  localparam int DW = 48;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          valid = 1'b0;
  logic [DW-1:0] data = '0;
  logic          sel = 1'b0;   // 0: 4x4 instance, 1: 5x5 instance

  logic          va, vb, busy_a, busy_b, done_a, done_b;
  logic [DW-1:0] da, db;

  always #5 clk = ~clk;

  maxpool_ctrl #(.IN_SIZE(4), .POOL_SIZE(2), .DATA_W(DW)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start && !sel), .i_valid(valid && !sel),
    .i_data(data), .o_valid(va), .o_data(da), .o_busy(busy_a), .o_done(done_a)
  );

  maxpool_ctrl #(.IN_SIZE(5), .POOL_SIZE(2), .DATA_W(DW)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start && sel), .i_valid(valid && sel),
    .i_data(data), .o_valid(vb), .o_data(db), .o_busy(busy_b), .o_done(done_b)
  );

  logic          cur_v, cur_busy, cur_done;
  logic [DW-1:0] cur_d;
  assign cur_v    = sel ? vb : va;
  assign cur_d    = sel ? db : da;
  assign cur_busy = sel ? busy_b : busy_a;
  assign cur_done = sel ? done_b : done_a;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_cyc = -2;
  int busy_bad = 0;

  logic signed [DW-1:0] stim[$];
  logic signed [DW-1:0] exp_q[$];
  logic signed [DW-1:0] cap_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cur_v) cap_q.push_back(cur_d);
    if (cur_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: each pooled value is the plain maximum of its 2x2 window.
  task automatic build_expected(input int n);
    logic signed [DW-1:0] m;
    int o;
    o = n / 2;
    exp_q.delete();
    for (int r = 0; r < o; r++) begin
      for (int c = 0; c < o; c++) begin
        m = stim[(2 * r) * n + 2 * c];
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++)
            if (stim[(2 * r + dr) * n + 2 * c + dc] > m) m = stim[(2 * r + dr) * n + 2 * c + dc];
        exp_q.push_back(m);
      end
    end
  endtask

  // gap_mode: 0 continuous, 1 idle cycle before every sample, 2 random idle cycles.
  task automatic drive_frame(input int nsamp, input int gap_mode);
    int gaps;
    cap_q.delete();
    done_cnt = 0;
    done_cyc = -1;
    busy_bad = 0;
    start = 1'b1;
    valid = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < nsamp; i++) begin
      gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < gaps; g++) begin
        valid = 1'b0;
        if (!cur_busy) busy_bad++;
        step();
      end
      valid = 1'b1;
      data  = stim[i];
      if (!cur_busy) busy_bad++;
      step();
      last_cyc = cyc;
    end
    valid = 1'b0;
  endtask

  task automatic compare_frame(input string tag);
    check({tag, "_count"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      check($sformatf("%s_out%0d", tag, i), cap_q[i], exp_q[i]);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_cyc"}, done_cyc, last_cyc);
  endtask

  task automatic fill_ramp(input int n, input longint base, input longint stride);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(DW'(base + stride * i));
  endtask

  task automatic fill_random(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(DW'({$urandom, $urandom}));
  endtask

  logic signed [DW-1:0] spec1[4];

  initial begin
    spec1[0] = 5; spec1[1] = 7; spec1[2] = 13; spec1[3] = 15;

    // Reset state of both instances
    repeat (3) step();
    check("rst_a_valid", va, 0);
    check("rst_a_data", da, 0);
    check("rst_a_busy", busy_a, 0);
    check("rst_a_done", done_a, 0);
    check("rst_b_valid", vb, 0);
    check("rst_b_busy", busy_b, 0);
    rst = 1'b0;
    step();

    // 1: 4x4 ramp 0..15, continuous
    sel = 1'b0;
    fill_ramp(16, 0, 1);
    build_expected(4);
    drive_frame(16, 0);
    repeat (3) step();
    compare_frame("t1");
    for (int i = 0; i < 4 && i < cap_q.size(); i++)
      check($sformatf("t1_spec%0d", i), cap_q[i], spec1[i]);

    // 2: negative ramp, signed compare
    fill_ramp(16, -1, -1);
    build_expected(4);
    drive_frame(16, 0);
    repeat (3) step();
    compare_frame("t2");

    // 3: ramp with an idle cycle before each sample
    fill_ramp(16, 0, 1);
    build_expected(4);
    drive_frame(16, 1);
    repeat (3) step();
    compare_frame("t3");
    check("t3_busy_low", busy_bad, 0);

    // 4: 5x5 ramp, last row and column discarded
    sel = 1'b1;
    fill_ramp(25, 0, 1);
    build_expected(5);
    drive_frame(25, 0);
    repeat (3) step();
    compare_frame("t4");

    // 5: reset after 6 samples, then a fresh frame
    fill_ramp(25, 1000, 3);
    drive_frame(6, 0);
    rst = 1'b1;
    step();
    check("t5_rst_busy", cur_busy, 0);
    check("t5_rst_valid", cur_v, 0);
    check("t5_rst_data", cur_d, 0);
    step();
    rst = 1'b0;
    repeat (4) step();
    check("t5_abort_outputs", cap_q.size(), 0);
    check("t5_abort_done", done_cnt, 0);
    fill_random(25);
    build_expected(5);
    drive_frame(25, 2);
    repeat (3) step();
    compare_frame("t5");

    // 6: restart after 9 samples; only the new frame's results count
    sel = 1'b0;
    fill_ramp(16, 0, 1);
    drive_frame(9, 0);
    step();
    fill_ramp(16, 200, -7);
    build_expected(4);
    drive_frame(16, 0);
    repeat (3) step();
    compare_frame("t6");

    // Random frames on both geometries
    for (int k = 0; k < 4; k++) begin
      sel = k[0];
      fill_random(sel ? 25 : 16);
      build_expected(sel ? 5 : 4);
      drive_frame(sel ? 25 : 16, 2);
      repeat (3) step();
      compare_frame($sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
